// File: rtl/alu_exec_stage.sv
// Registered execute stage around the external combinational ALU.
// Tokens are held in a one-entry issue register that drives the ALU. Masked results go into a
// 2-entry output FIFO. The stage also keeps a sticky overflow flag and a completed-op counter.
module alu_exec_stage #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow,
  input  logic             alu_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_overflow,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_illegal,
  output logic             sticky_ovf,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] op_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             carry;
    logic             zero;
    logic             illegal;
  } entry_t;

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;
  logic [2:0]       s1_op_q;

  entry_t           fifo_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;

  logic             out_fire;
  logic             s1_adv;
  logic             in_fire;
  entry_t           wr_entry;
  entry_t           head;

  assign out_valid = (cnt_q != 2'd0);
  assign out_fire  = out_valid & out_ready;
  // The issue register may drain into a full FIFO when the head leaves on the same edge.
  assign s1_adv    = s1_valid_q & ((cnt_q != 2'd2) | out_fire);
  assign in_ready  = ~s1_valid_q | s1_adv;
  assign in_fire   = in_valid & in_ready;

  assign alu_a       = s1_a_q;
  assign alu_b       = s1_b_q;
  assign alu_control = s1_op_q;

  // Issue register: load on accept, otherwise empty out when its token moves into the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= 3'b000;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= in_a;
      s1_b_q     <= in_b;
      s1_op_q    <= in_op;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Per-opcode masking of the ALU outputs into the FIFO entry.
  always_comb begin
    wr_entry = '0;
    case (s1_op_q)
      3'b000, 3'b001: begin
        wr_entry.result   = alu_result;
        wr_entry.overflow = alu_overflow;
        wr_entry.carry    = alu_carry;
      end
      3'b010, 3'b011, 3'b101: begin
        wr_entry.result = alu_result;
      end
      default: begin
        wr_entry.illegal = 1'b1;
      end
    endcase
    wr_entry.zero = (wr_entry.result == '0);
  end

  // Output FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (s1_adv) begin
        fifo_q[wr_ptr_q] <= wr_entry;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (out_fire) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, s1_adv} - {1'b0, out_fire};
    end
  end

  assign head         = fifo_q[rd_ptr_q];
  assign out_result   = head.result;
  assign out_overflow = head.overflow;
  assign out_carry    = head.carry;
  assign out_zero     = head.zero;
  assign out_illegal  = head.illegal;

  // Sticky overflow: a new overflowing write beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
    end else if (s1_adv && wr_entry.overflow) begin
      sticky_ovf <= 1'b1;
    end else if (sticky_clr) begin
      sticky_ovf <= 1'b0;
    end
  end

  // Completed-operation counter, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count <= '0;
    end else if (out_fire) begin
      op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage with a behavioural ALU and a scoreboard model.
module tb_alu_exec_stage;

  typedef struct packed {
    logic [31:0] result;
    logic        overflow;
    logic        carry;
    logic        zero;
    logic        illegal;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [2:0]  in_op = '0;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_overflow, alu_carry;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_overflow, out_carry, out_zero, out_illegal;
  logic        sticky_ovf;
  logic        sticky_clr = 1'b0;
  logic [15:0] op_count;

  int          tests = 0;
  int          fails = 0;
  exp_t        exp_q[$];
  logic [31:0] got_q[$];
  logic [15:0] exp_cnt = '0;
  logic        sticky_acc = 1'b0;

  alu_exec_stage #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_carry(out_carry), .out_zero(out_zero),
    .out_illegal(out_illegal), .sticky_ovf(sticky_ovf), .sticky_clr(sticky_clr),
    .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: adder flags are produced for every opcode so masking is exercised.
  logic        is_sub;
  logic [31:0] bb;
  logic [32:0] sum;
  always_comb begin
    is_sub = (alu_control == 3'b001);
    bb     = is_sub ? ~alu_b : alu_b;
    sum    = {1'b0, alu_a} + {1'b0, bb} + {32'd0, is_sub};
    alu_carry    = sum[32];
    alu_overflow = (alu_a[31] == bb[31]) && (sum[31] != alu_a[31]);
    case (alu_control)
      3'b000, 3'b001: alu_result = sum[31:0];
      3'b010:         alu_result = alu_a & alu_b;
      3'b011:         alu_result = alu_a ^ alu_b;
      3'b101:         alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      default:        alu_result = alu_a | alu_b;
    endcase
  end

  function automatic exp_t ref_model(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    exp_t e;
    longint unsigned s;
    e = '0;
    case (op)
      3'd0: begin
        s = longint'(a) + longint'(b);
        e.result = s[31:0];
        e.carry = s[32];
        e.overflow = (a[31] == b[31]) && (e.result[31] != a[31]);
      end
      3'd1: begin
        e.result = a - b;
        e.carry = (a >= b);
        e.overflow = (a[31] != b[31]) && (e.result[31] != a[31]);
      end
      3'd2: e.result = a & b;
      3'd3: e.result = a ^ b;
      3'd5: e.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.illegal = 1'b1;
    endcase
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: handshakes are sampled on the falling edge and complete on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      exp_cnt = '0;
      sticky_acc = 1'b0;
    end else begin
      chk("op_count", {48'd0, op_count}, {48'd0, exp_cnt});
      if (out_valid && out_ready) begin
        got_q.push_back(out_result);
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'd1, 64'd0);
        end else begin
          chk("sb_entry", {28'd0, out_result, out_overflow, out_carry, out_zero, out_illegal},
              {28'd0, exp_q.pop_front()});
        end
        exp_cnt = exp_cnt + 16'd1;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_model(in_op, in_a, in_b));
        sticky_acc = sticky_acc | ref_model(in_op, in_a, in_b).overflow;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hard_reset();
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    sticky_clr = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  // Present a token and hold it until accepted; returns 1ns after the accepting edge.
  task automatic send_token(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic acc;
    in_valid = 1'b1;
    in_op = op;
    in_a = a;
    in_b = b;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      if (acc) begin
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("accept_timeout", 64'd1, 64'd0);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    for (int n = 0; n < 50 && (exp_q.size() != 0 || out_valid); n++) tick();
    chk("drain_empty", {63'd0, out_valid}, 64'd0);
  endtask

  // Send one token into an empty stage, check latency and the head contents.
  task automatic one_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e);
    out_ready = 1'b1;
    send_token(op, a, b);
    chk({name, ".early"}, {63'd0, out_valid}, 64'd0);
    tick();
    chk({name, ".valid"}, {63'd0, out_valid}, 64'd1);
    chk({name, ".entry"}, {28'd0, out_result, out_overflow, out_carry, out_zero, out_illegal},
        {28'd0, e});
    tick();
  endtask

  vec_t        vecs [10];
  logic [31:0] edge_vals [6];
  logic [31:0] stall_exp [4];
  int          acc_n;
  logic        r;

  initial begin
    vecs[0] = '{3'b000, 32'd10,        32'd5,        '{32'd15,        1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{3'b000, 32'hFFFFFFFF, 32'd1,        '{32'd0,         1'b0, 1'b1, 1'b1, 1'b0}};
    vecs[2] = '{3'b101, 32'hFFFFFFFB, 32'd10,       '{32'd1,         1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[3] = '{3'b110, 32'd7,         32'd3,        '{32'd0,         1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[4] = '{3'b100, 32'hFFFF0000, 32'h0000FFFF, '{32'd0,         1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[5] = '{3'b111, 32'h80000000, 32'h80000000, '{32'd0,         1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[6] = '{3'b001, 32'd3,         32'd5,        '{32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[7] = '{3'b001, 32'd9,         32'd9,        '{32'd0,         1'b0, 1'b1, 1'b1, 1'b0}};
    vecs[8] = '{3'b010, 32'hFFFFFFFF, 32'h80000001, '{32'h80000001, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[9] = '{3'b011, 32'h80000000, 32'h80000000, '{32'd0,         1'b0, 1'b0, 1'b1, 1'b0}};
    edge_vals = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h1, 32'hFFFFFFFE};
    stall_exp = '{32'd2, 32'd5, 32'h00000FF0, 32'h0000F000};

    // Reset state
    #3;
    chk("rst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst.in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst.data", {alu_a, out_result}, 64'd0);
    chk("rst.count", {47'd0, sticky_ovf, op_count}, 64'd0);
    hard_reset();

    // Table-driven single operations
    for (int i = 0; i < 10; i++) begin
      one_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
    end
    chk("table.sticky", {63'd0, sticky_ovf}, 64'd0);

    // Overflow sets sticky, held until clear; clear and new overflow on the same edge keep it set
    one_op("ovf", 3'b000, 32'h7FFFFFFF, 32'd1, '{32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0});
    chk("sticky.set", {63'd0, sticky_ovf}, 64'd1);
    repeat (3) tick();
    chk("sticky.hold", {63'd0, sticky_ovf}, 64'd1);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("sticky.clr", {63'd0, sticky_ovf}, 64'd0);
    send_token(3'b000, 32'h7FFFFFFF, 32'd1);
    sticky_clr = 1'b1;
    tick();
    sticky_clr = 1'b0;
    chk("sticky.set_wins", {63'd0, sticky_ovf}, 64'd1);
    drain();

    // Stall: 3 tokens absorbed, fourth refused until the output drains
    hard_reset();
    out_ready = 1'b0;
    got_q.delete();
    acc_n = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      case (i)
        0: begin in_op = 3'b000; in_a = 32'd1;      in_b = 32'd1;      end
        1: begin in_op = 3'b001; in_a = 32'd9;      in_b = 32'd4;      end
        2: begin in_op = 3'b011; in_a = 32'hF0F0;   in_b = 32'hFF00;   end
        default: begin in_op = 3'b010; in_a = 32'hF0F0; in_b = 32'hFF00; end
      endcase
      @(negedge clk);
      r = in_ready;
      tick();
      if (r) acc_n++;
    end
    chk("stall.accepted", 64'(acc_n), 64'd3);
    chk("stall.in_ready", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    send_token(3'b010, 32'hF0F0, 32'hFF00);
    drain();
    chk("stall.n_out", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      chk($sformatf("stall.out%0d", i), {32'd0, got_q[i]}, {32'd0, stall_exp[i]});
    end
    chk("stall.op_count", {48'd0, op_count}, 64'd4);

    // Asynchronous reset with tokens in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_token(3'b000, 32'(i + 1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("arst.op_count", {48'd0, op_count}, 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    got_q.delete();
    repeat (10) tick();
    chk("arst.no_output", 64'(got_q.size()), 64'd0);

    // Randomized traffic against the scoreboard
    hard_reset();
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      in_op     = 3'($urandom_range(0, 7));
      in_a      = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      in_b      = ($urandom_range(0, 3) == 0) ? edge_vals[$urandom_range(0, 5)] : $urandom;
      tick();
    end
    drain();
    chk("rand.sb_empty", 64'(exp_q.size()), 64'd0);
    chk("rand.sticky", {63'd0, sticky_ovf}, {63'd0, sticky_acc});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
